// File: rtl/anita_scaler_pkg.sv
// Shared types and helpers for the ANITA deadtime scaler bank.
package anita_scaler_pkg;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } mode_e;

  // Exponent of the reported scaler LSB, in counted events.
  function automatic int scaler_lsb_exp(input int prescale_bits, input int cnt_bits,
                                        input int out_bits);
    return prescale_bits + cnt_bits - out_bits;
  endfunction

endpackage

// File: rtl/anita_deadtime_channel.sv
// One deadtime channel: edge detect, interval mode, prescaler, saturating
// accumulator and the per-second latch of its top bits.
module anita_deadtime_channel
  import anita_scaler_pkg::*;
#(
  parameter int PRESCALE_BITS = 5,
  parameter int CNT_BITS      = 23,
  parameter int OUT_BITS      = 16
) (
  input  logic                clk250_i,
  input  logic                rst_i,
  input  logic                dead_i,
  input  logic                mode_i,
  input  logic                pps_i,
  output logic [OUT_BITS-1:0] scaler_o,
  output logic                ovf_o
);

  logic                     dead_q;
  mode_e                    mode_q;
  logic [PRESCALE_BITS-1:0] presc;
  logic [CNT_BITS-1:0]      cnt;
  logic                     ovf_acc;
  logic                     evt;

  always_comb begin
    evt = (mode_q == MODE_EDGE) ? (dead_i & ~dead_q) : dead_i;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, e.g. the latch below sees cnt before its clear.
  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      dead_q   <= 1'b0;
      mode_q   <= MODE_LEVEL;
      presc    <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      scaler_o <= '0;
      ovf_o    <= 1'b0;
    end else begin
      dead_q <= dead_i;
      if (pps_i) begin
        // Interval boundary wins; an event in this cycle is dropped.
        scaler_o <= cnt[CNT_BITS-1 -: OUT_BITS];
        ovf_o    <= ovf_acc;
        presc    <= '0;
        cnt      <= '0;
        ovf_acc  <= 1'b0;
        mode_q   <= mode_e'(mode_i);
      end else if (evt) begin
        presc <= presc + PRESCALE_BITS'(1);
        if (&presc) begin
          if (&cnt) ovf_acc <= 1'b1;
          else      cnt     <= cnt + CNT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: rtl/anita_deadtime_scaler_bank.sv
// NCH-channel deadtime/occupancy scaler bank latched on PPS, clk250 domain.
module anita_deadtime_scaler_bank #(
  parameter int NCH           = 4,
  parameter int PRESCALE_BITS = 5,
  parameter int CNT_BITS      = 23,
  parameter int OUT_BITS      = 16
) (
  input  logic                    clk250_i,
  input  logic                    rst_i,
  input  logic [NCH-1:0]          dead_i,
  input  logic [NCH-1:0]          mode_i,
  input  logic                    pps_i,
  output logic [NCH*OUT_BITS-1:0] scaler_o,
  output logic [NCH-1:0]          ovf_o,
  output logic                    valid_o
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    anita_deadtime_channel #(
      .PRESCALE_BITS(PRESCALE_BITS),
      .CNT_BITS     (CNT_BITS),
      .OUT_BITS     (OUT_BITS)
    ) u_ch (
      .clk250_i(clk250_i),
      .rst_i   (rst_i),
      .dead_i  (dead_i[k]),
      .mode_i  (mode_i[k]),
      .pps_i   (pps_i),
      .scaler_o(scaler_o[k*OUT_BITS +: OUT_BITS]),
      .ovf_o   (ovf_o[k])
    );
  end

  always_ff @(posedge clk250_i) begin
    if (rst_i) valid_o <= 1'b0;
    else       valid_o <= pps_i;
  end

endmodule
